// File: rtl/vga_timing_pkg.sv
// +----------------------------------------------------------------------+
// | vga_timing_pkg                                                       |
// | 640x480 VGA timing constants and the sync-decoder lock states.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package vga_timing_pkg;

   localparam int c_h_total      = 800;
   localparam int c_h_active     = 640;
   localparam int c_h_sync_start = 655;
   localparam int c_h_sync_end   = 750;
   localparam int c_v_total      = 525;
   localparam int c_v_active     = 480;
   localparam int c_v_sync_start = 489;
   localparam int c_v_sync_end   = 490;
   localparam int c_frame_h      = 660;
   localparam int c_frame_v      = 490;
   localparam int c_loss_count   = 3;
   localparam int c_wdog_cycles  = 1600;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      H_LOCK = 2'd1,
      LOCKED = 2'd2
   } lock_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_edge_det.sv
// +----------------------------------------------------------------------+
// | vga_edge_det                                                         |
// | One-bit edge detector; the delay register idles high (sync inactive).|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic i_din,
   output logic o_fall,
   output logic o_rise
);

   logic r_d;

   always_ff @(posedge clk) begin
      if (reset) r_d <= 1'b1;
      else       r_d <= i_din;
   end

   assign o_fall = r_d & ~i_din;
   assign o_rise = ~r_d & i_din;

endmodule

`default_nettype wire

// File: rtl/vga_sync_decoder.sv
// +----------------------------------------------------------------------+
// | vga_sync_decoder                                                     |
// | Recovers column/row, active region and frame strobe from VGA syncs.  |
// | Optional macro VGA_SYNC_CDC_EN adds a 2-flop input synchronizer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_sync_decoder
   import vga_timing_pkg::*;
#(
   parameter int H_TOTAL      = c_h_total,
   parameter int H_ACTIVE     = c_h_active,
   parameter int H_SYNC_START = c_h_sync_start,
   parameter int H_SYNC_END   = c_h_sync_end,
   parameter int V_TOTAL      = c_v_total,
   parameter int V_ACTIVE     = c_v_active,
   parameter int V_SYNC_START = c_v_sync_start,
   parameter int V_SYNC_END   = c_v_sync_end,
   parameter int LOSS_COUNT   = c_loss_count,
   parameter int WDOG_CYCLES  = c_wdog_cycles
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] hq,
   output logic [9:0] vq,
   output logic       ar,
   output logic       frame,
   output logic       locked,
   output logic       sync_err
);

   localparam int c_wd_w   = $clog2(WDOG_CYCLES + 1);
   localparam int c_miss_w = $clog2(LOSS_COUNT + 1);

   localparam logic [9:0] c_h_last     = 10'(H_TOTAL - 1);
   localparam logic [9:0] c_v_last     = 10'(V_TOTAL - 1);
   localparam logic [9:0] c_h_act      = 10'(H_ACTIVE);
   localparam logic [9:0] c_v_act      = 10'(V_ACTIVE);
   localparam logic [9:0] c_hs_start   = 10'(H_SYNC_START);
   localparam logic [9:0] c_hs_reload  = 10'(H_SYNC_START + 1);
   localparam logic [9:0] c_hs_rise    = 10'(H_SYNC_END + 1);
   localparam logic [9:0] c_vs_start   = 10'(V_SYNC_START);
   localparam logic [9:0] c_fr_h       = 10'(c_frame_h);
   localparam logic [9:0] c_fr_v       = 10'(c_frame_v);
   localparam logic [c_wd_w-1:0]   c_wdog_lim  = c_wd_w'(WDOG_CYCLES);
   localparam logic [c_miss_w-1:0] c_miss_last = c_miss_w'(LOSS_COUNT - 1);

   logic w_hs;
   logic w_vs;

`ifdef VGA_SYNC_CDC_EN
   logic [1:0] r_hs_sync;
   logic [1:0] r_vs_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hs_sync <= 2'b11;
         r_vs_sync <= 2'b11;
      end else begin
         r_hs_sync <= {r_hs_sync[0], hsync};
         r_vs_sync <= {r_vs_sync[0], vsync};
      end
   end

   assign w_hs = r_hs_sync[1];
   assign w_vs = r_vs_sync[1];
`else
   assign w_hs = hsync;
   assign w_vs = vsync;
`endif

   logic w_hfall;
   logic w_hrise;
   logic w_vfall;
   logic w_vrise_unused;

   vga_edge_det u_hedge (
      .clk    (clk),
      .reset  (reset),
      .i_din  (w_hs),
      .o_fall (w_hfall),
      .o_rise (w_hrise)
   );

   vga_edge_det u_vedge (
      .clk    (clk),
      .reset  (reset),
      .i_din  (w_vs),
      .o_fall (w_vfall),
      .o_rise (w_vrise_unused)
   );

   lock_state_t         r_state;
   logic [9:0]          r_hq;
   logic [9:0]          r_vq;
   logic [c_miss_w-1:0] r_miss;
   logic [c_wd_w-1:0]   r_wdog;
   logic                r_sync_err;

   logic              w_hfall_ok;
   logic              w_mis;
   logic [c_wd_w-1:0] w_wdog_inc;
   logic              w_wdog_hit;

   assign w_hfall_ok = (r_hq == c_hs_start);
   assign w_mis      = (w_hfall && !w_hfall_ok)
                     || (w_hrise && (r_hq != c_hs_rise))
                     || (w_vfall && !((r_hq == 10'd0) && (r_vq == c_vs_start)));
   assign w_wdog_inc = r_wdog + 1'b1;
   assign w_wdog_hit = !w_hfall && (w_wdog_inc == c_wdog_lim);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= SEARCH;
         r_hq       <= 10'd0;
         r_vq       <= 10'd0;
         r_miss     <= '0;
         r_wdog     <= '0;
         r_sync_err <= 1'b0;
      end else begin
         // An aligned edge while locked is left to the free-running count.
         if (w_hfall && !((r_state == LOCKED) && w_hfall_ok)) r_hq <= c_hs_reload;
         else if (r_hq == c_h_last)                            r_hq <= 10'd0;
         else                                                  r_hq <= r_hq + 10'd1;

         if (w_vfall)              r_vq <= c_vs_start;
         else if (r_hq == c_h_last) r_vq <= (r_vq == c_v_last) ? 10'd0 : r_vq + 10'd1;

         r_sync_err <= w_mis && (r_state != SEARCH);

         if (w_hfall || w_wdog_hit) r_wdog <= '0;
         else                       r_wdog <= w_wdog_inc;

         case (r_state)
            SEARCH: begin
               r_miss <= '0;
               if (w_hfall) r_state <= H_LOCK;
            end
            H_LOCK: begin
               if (w_hfall && !w_hfall_ok)          r_state <= SEARCH;
               else if (w_vfall && (r_hq == 10'd0)) r_state <= LOCKED;
            end
            LOCKED: begin
               if (w_mis) begin
                  if (r_miss == c_miss_last) begin
                     r_state <= SEARCH;
                     r_miss  <= '0;
                  end else begin
                     r_miss <= r_miss + 1'b1;
                  end
               end else if (w_hfall) begin
                  r_miss <= '0;
               end
            end
            default: r_state <= SEARCH;
         endcase

         if (w_wdog_hit && (r_state != SEARCH)) begin
            r_state <= SEARCH;
            r_miss  <= '0;
         end
      end
   end

   assign hq       = r_hq;
   assign vq       = r_vq;
   assign locked   = (r_state == LOCKED);
   assign ar       = locked && (r_hq < c_h_act) && (r_vq < c_v_act);
   assign frame    = locked && (r_hq == c_fr_h) && (r_vq == c_fr_v);
   assign sync_err = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
// +----------------------------------------------------------------------+
// | tb_vga_sync_decoder                                                  |
// | Randomized VGA source against a behavioural decoder reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_vga_sync_decoder;

`ifdef VGA_SYNC_CDC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       hsync;
   logic       vsync;
   logic [9:0] hq;
   logic [9:0] vq;
   logic       ar;
   logic       frame;
   logic       locked;
   logic       sync_err;

   always #5 clk = ~clk;

   vga_sync_decoder dut (
      .clk      (clk),
      .reset    (reset),
      .hsync    (hsync),
      .vsync    (vsync),
      .hq       (hq),
      .vq       (vq),
      .ar       (ar),
      .frame    (frame),
      .locked   (locked),
      .sync_err (sync_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // source generator state
   int src_h, src_v, h_shift;
   bit h_kill, ideal;
   int n_frames = 0;

   // reference model state (0=search, 1=h-lock, 2=locked)
   int m_hq, m_vq, m_st, m_cnt, m_wd;
   bit m_err, m_hd, m_vd, m_s1h, m_s2h, m_s1v, m_s2v;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t src %0d,%0d)", tag, obs, exp, $time, src_h, src_v);
      end
   endtask

   task automatic model_reset();
      m_hq = 0; m_vq = 0; m_st = 0; m_cnt = 0; m_wd = 0; m_err = 0;
      m_hd = 1; m_vd = 1; m_s1h = 1; m_s2h = 1; m_s1v = 1; m_s2v = 1;
   endtask

   task automatic model_step(input bit rst, input bit hs, input bit vs);
      bit eh, ev, hf, hr, vf, mis;
      int wd_n, st_n, cnt_n;
      if (rst) begin
         model_reset();
         return;
      end
`ifdef VGA_SYNC_CDC_EN
      eh = m_s2h; ev = m_s2v;
      m_s2h = m_s1h; m_s1h = hs;
      m_s2v = m_s1v; m_s1v = vs;
`else
      eh = hs; ev = vs;
`endif
      hf  = m_hd && !eh;
      hr  = !m_hd && eh;
      vf  = m_vd && !ev;
      mis = (hf && m_hq != 655) || (hr && m_hq != 751) || (vf && !(m_hq == 0 && m_vq == 489));
      st_n  = m_st;
      cnt_n = m_cnt;
      wd_n  = hf ? 0 : m_wd + 1;
      case (m_st)
         0: if (hf) st_n = 1;
         1: if (hf && m_hq != 655) st_n = 0; else if (vf && m_hq == 0) st_n = 2;
         default: begin
            if (mis) begin
               cnt_n++;
               if (cnt_n >= 3) st_n = 0;
            end else if (hf) cnt_n = 0;
         end
      endcase
      if (wd_n >= 1600) begin
         wd_n = 0;
         if (m_st != 0) st_n = 0;
      end
      if (st_n == 0) cnt_n = 0;
      m_err = mis && (m_st != 0);
      m_vq  = vf ? 489 : (m_hq == 799 ? (m_vq + 1) % 525 : m_vq);
      m_hq  = (hf && !(m_st == 2 && m_hq == 655)) ? 656 : (m_hq + 1) % 800;
      m_hd  = eh; m_vd = ev;
      m_st  = st_n; m_cnt = cnt_n; m_wd = wd_n;
   endtask

   task automatic tick(input bit rst, input bit glt);
      bit hs, vs, e_lock;
      @(negedge clk);
      e_lock = (m_st == 2);
      check_value("hq", 32'(hq), 32'(m_hq));
      check_value("vq", 32'(vq), 32'(m_vq));
      check_value("locked", 32'(locked), 32'(e_lock));
      check_value("ar", 32'(ar), 32'(e_lock && m_hq < 640 && m_vq < 480));
      check_value("frame", 32'(frame), 32'(e_lock && m_hq == 660 && m_vq == 490));
      check_value("sync_err", 32'(sync_err), 32'(m_err));
      if (ideal) begin
         if (src_v == 489 && src_h == LAT)     check_value("lock_before_vfall", 32'(locked), 32'd0);
         if (src_v == 489 && src_h == LAT + 1) check_value("lock_after_vfall", 32'(locked), 32'd1);
         if (frame === 1'b1) begin
            n_frames++;
            check_value("frame_src_h", 32'(src_h), 32'(660 + LAT));
            check_value("frame_src_v", 32'(src_v), 32'd490);
         end
      end
      hs = 1'b1;
      if (!h_kill && src_h >= 655 + h_shift && src_h <= 750 + h_shift) hs = 1'b0;
      if (glt) hs = ~hs;
      vs = !(src_v == 489 || src_v == 490);
      hsync = hs;
      vsync = vs;
      reset = rst;
      model_step(rst, hs, vs);
      src_h++;
      if (src_h == 800) begin
         src_h = 0;
         src_v = (src_v + 1) % 525;
      end
   endtask

   // runs the source up to the start of the next line
   task automatic run_line(input int shift, input bit kill, input int glitch_div);
      bit g;
      h_shift = shift;
      h_kill  = kill;
      do begin
         g = 1'b0;
         if (glitch_div > 0) g = ($urandom_range(glitch_div - 1, 0) == 0);
         tick(1'b0, g);
      end while (src_h != 0);
      h_shift = 0;
      h_kill  = 1'b0;
   endtask

   initial begin
      int r;
      reset = 1'b1; hsync = 1'b1; vsync = 1'b1;
      model_reset();
      src_h = 0; src_v = 487; h_shift = 0; h_kill = 1'b0; ideal = 1'b1;

      // ideal timing through lock, one frame strobe and the row wrap
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      repeat (40) run_line(0, 1'b0, 0);
      check_value("frames_in_window", 32'(n_frames), 32'd1);
      ideal = 1'b0;

      // early hsync edges
      run_line(-4, 1'b0, 0);
      repeat (3) run_line(0, 1'b0, 0);
      repeat (3) run_line(-4, 1'b0, 0);
      repeat (2) run_line(0, 1'b0, 0);

      // relock, then hsync held high past the watchdog, then relock
      src_v = 488;
      repeat (3) run_line(0, 1'b0, 0);
      repeat (2) run_line(0, 1'b1, 0);
      run_line(0, 1'b0, 0);
      src_v = 488;
      repeat (3) run_line(0, 1'b0, 0);

      // single-cycle reset mid-line, then relock
      src_v = 487;
      run_line(0, 1'b0, 0);
      r = $urandom_range(699, 100);
      repeat (r) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      repeat (4) run_line(0, 1'b0, 0);

      // source jumps to a random mid-line position after reset
      tick(1'b1, 1'b0);
      src_h = $urandom_range(599, 0);
      src_v = 488;
      repeat (4) run_line(0, 1'b0, 0);

      // random shifts, glitches and row jumps
      repeat (6) begin
         src_v = $urandom_range(490, 486);
         run_line(int'($urandom_range(8, 0)) - 4, 1'b0, 400);
      end
      repeat (3) run_line(0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
